// File: rtl/mpy_result_fifo.sv
// Result-capture FIFO behind the Booth multiplier: first-word-fall-through buffer
// with a valid/ready output, a running signed accumulator and drop accounting.
module mpy_result_fifo #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 72
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [63:0]                i_product,
  input  logic                       i_product_valid,
  input  logic                       i_acc_clr,
  input  logic                       i_out_ready,
  output logic                       o_out_valid,
  output logic [63:0]                o_out_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [ACC_W-1:0]           o_acc,
  output logic                       o_overflow,
  output logic [7:0]                 o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [ACC_W-1:0] w_prod_ext;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = (r_count != '0) && i_out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push     = i_product_valid && (!w_full || w_pop);
  assign w_drop     = i_product_valid && w_full && !w_pop;
  assign w_prod_ext = ACC_W'($signed(i_product));

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_product;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_acc_clr) begin
      r_acc      <= w_push ? w_prod_ext : '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign o_out_valid = (r_count != '0);
  assign o_out_data  = r_mem[r_rptr];
  assign o_count     = r_count;
  assign o_acc       = r_acc;
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: doc/mpy_result_fifo.md
# mpy_result_fifo

Result-capture stage directly downstream of the 32-bit radix-4 Booth multiplier. Samples the 64-bit signed `Product` whenever `Product_Valid` pulses and buffers it in a small first-word-fall-through FIFO with a valid/ready output. It also keeps a running signed accumulation of accepted products for MAC-style use. Overflow is counted rather than back-pressured, because the multiplier is free-running and cannot stall.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ACC_W`, 72: accumulator width; ≥ 64.
- `CLK`  in  1: rising-edge clock.
- `RST_N`  in  1: asynchronous, active-low reset.
- `Product`  in  64: signed product; meaningful only while `Product_Valid`=1.
- `Product_Valid`  in  1: single-cycle strobe from the multiplier.
- `Acc_Clr`  in  1: synchronous clear of `Acc`, `Overflow`, `Drop_Cnt`.
- `Out_Ready`  in  1: consumer ready.
- `Out_Valid`  out  1: FIFO non-empty.
- `Out_Data`  out  64: head entry; equals the oldest accepted product.
- `Count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `Acc`  out  ACC_W: signed running sum of accepted products.
- `Overflow`  out  1: sticky; set when a product is dropped.
- `Drop_Cnt`  out  8: number of dropped products; saturates at 255.

## Operation
- **Push.** Occurs on any edge where `Product_Valid`=1 and the FIFO is not full.
  - A push is also accepted when the FIFO is full and a pop occurs on the same edge.
  - No other input is required for a push.
- **Pop.** Occurs on any edge where `Out_Valid`=1 and `Out_Ready`=1.
  - The head advances.
  - `Out_Data` shows the next entry combinationally from storage.
- **Simultaneous push and pop.** Both take effect. `Count` is unchanged and no entry is lost.
- **Drop.** Occurs when `Product_Valid`=1, the FIFO is full and there is no pop.
  - The product is discarded.
  - `Overflow` is set to 1.
  - `Drop_Cnt` increments, saturating at 255.
  - `Acc` is not updated.
- **Accumulate.** On each accepted push, `Acc` becomes `Acc` + sign-extend(`Product`) to ACC_W.
  - Arithmetic is modular 2^ACC_W; there is no saturation.
  - Dropped products are never added.
- **`Acc_Clr`.** `Acc`, `Overflow` and `Drop_Cnt` become 0.
  - If `Acc_Clr` coincides with an accepted push, `Acc` becomes sign-extend(`Product`).
  - If `Acc_Clr` coincides with a drop, the clear wins: `Overflow` is 0 and `Drop_Cnt` is 0.
  - `Acc_Clr` never affects FIFO contents or `Count`.
- **Storage.**
  - Circular buffer with wrap-around read/write pointers of $clog2(DEPTH) bits.
  - Full and empty are distinguished by an occupancy counter, not by pointer equality alone.
- **Reset (`RST_N`=0, asynchronous).**
  - Pointers and `Count` are 0.
  - `Out_Valid`=0, `Acc`=0, `Overflow`=0, `Drop_Cnt`=0.
  - `Out_Data` is a don't-care while `Out_Valid`=0; the bench checks it only when valid.
  - Reset mid-stream discards all buffered entries.
  - No push is accepted on the first edge after release unless `Product_Valid` is already high on it.

## Timing
- **Push-to-output latency.** A push on edge N gives `Out_Valid`=1 and `Out_Data`=product immediately after edge N. The same cycle may pop on edge N+1.
- **Upstream cadence.** The multiplier produces one result per 32-cycle counter wrap. The block accepts back-to-back `Product_Valid` pulses on consecutive cycles with no gap requirement.
- **Output handshake.**
  - While `Out_Valid`=1 and `Out_Ready`=0, `Out_Data` and `Out_Valid` are held stable.
  - `Out_Valid` never depends combinationally on `Out_Ready`.
- **Output timing.**
  - `Count`, `Acc`, `Overflow` and `Drop_Cnt` are registered and update on the same edge as the causing event.
  - `Out_Valid` and `Out_Data` are decoded from registered state.
- **No combinational paths.** There is no path from `Product`/`Product_Valid` to any output.

## Test plan
1. **Reset values.** Hold `RST_N`=0, then release → all outputs 0 and `Out_Valid`=0; assert `RST_N` mid-cycle → outputs clear without a clock edge.
2. **Single product, both signs.** `Product`=64'hFFFF_FFFF_FFFF_FFFA (−6) strobed with `Out_Ready`=0 → `Out_Valid`=1, `Out_Data`=−6, `Count`=1, `Acc`=−6 (72-bit sign-extended). Then a second product +100 → `Acc`=94, `Count`=2.
3. **Fill and drop.** Five strobes (1,2,3,4,5) with `Out_Ready`=0, DEPTH=4 → `Count`=4, `Overflow`=1, `Drop_Cnt`=1, `Acc`=10. Draining gives 1,2,3,4 in order, then `Out_Valid`=0.
4. **Full with simultaneous push/pop.** FIFO full (1..4), strobe 9 with `Out_Ready`=1 → pops 1, accepts 9, `Count`=4, `Overflow`=0, `Acc` +9. Drain order is 2,3,4,9.
5. **Clear interactions.**
   - `Acc_Clr` together with an accepted push of 7 → `Acc`=7.
   - `Acc_Clr` together with a drop → `Overflow`=0, `Drop_Cnt`=0.
   - 300 drops without a clear → `Drop_Cnt`=255.
6. **Accumulator wrap and end-to-end.** Preload via pushes of 64'h7FFF_FFFF_FFFF_FFFF repeated 512 times → `Acc` wraps modulo 2^72, matching the reference model. Then chain the real multiplier: in_a=−3, in_b=7 → `Out_Data`=−21.
